// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage in front of the control unit. Holds the PC, reads one word at a
// time from instruction memory over a req/valid handshake, presents the
// instruction and its decoded op/func3/func7 fields downstream, and advances
// the PC when the downstream stage consumes the instruction. At most one
// fetch is in flight; nothing is speculated.
//
// Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//   defined   - a misaligned next PC on a consume is loaded as computed, raises
//               misalign and parks the FSM in ERROR until reset.
//   undefined - next PC bits [1:0] are cleared, misalign is tied low.
//
// Parameters:
//   XLEN      width of PC, address, immediate and instruction data
//   RESET_PC  PC loaded on reset (multiple of 4)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_addr/req       memory read address (= pc) and request
//   imem_rdata/valid    memory read data and its valid strobe
//   instr, instr_valid  latched instruction and downstream valid
//   id_ready            downstream consumes the instruction this cycle
//   pc_src, imm_ext     branch select and immediate, sampled on consume
//   pc, pc_plus4        current instruction address and pc + 4
//   op, func3, func7    instr[6:0], instr[14:12], instr[30]
//   fetch_count         number of consumed instructions
//   misalign            misaligned-target flag (trap build only)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_valid,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            id_ready,
  input  logic            pc_src,
  input  logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      func3,
  output logic            func7,
  output logic [31:0]     fetch_count,
  output logic            misalign
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERROR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
`endif

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_instr_valid;
  logic            r_imem_req;
  logic [31:0]     r_fetch_count;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_target;

  // Both adds wrap modulo 2^XLEN; overflow is not an error.
  assign w_pc_plus4  = r_pc + XLEN'(4);
  assign w_pc_target = pc_src ? (r_pc + imm_ext) : w_pc_plus4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_target_misaligned;
  assign w_target_misaligned = (w_pc_target[1:0] != 2'b00);
`endif

  // imem_req and instr_valid are registered and updated on every state
  // transition, so they always match the state they belong to.
  // NOTE: all state uses non-blocking assignments under an asynchronous
  // reset; the reset branch clears every register so a reset landing
  // mid-fetch drops the request immediately, without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_fetch_count <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      case (r_state)
        // One quiet cycle after reset, so a late response from before the
        // reset cannot be mistaken for the first fetch.
        S_IDLE: begin
          r_imem_req <= 1'b1;
          r_state    <= S_REQ;
        end

        S_REQ: begin
          if (imem_valid) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (id_ready) begin
            r_instr_valid <= 1'b0;
            r_fetch_count <= r_fetch_count + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_pc <= w_pc_target;
            if (w_target_misaligned) begin
              r_misalign <= 1'b1;
              r_state    <= S_ERROR;
            end else begin
              r_imem_req <= 1'b1;
              r_state    <= S_REQ;
            end
`else
            r_pc       <= w_pc_target & ~XLEN'(3);
            r_imem_req <= 1'b1;
            r_state    <= S_REQ;
`endif
          end
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Trapped: no requests, nothing valid, only reset leaves.
        S_ERROR: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
`endif

        default: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign imem_req    = r_imem_req;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign op          = r_instr[6:0];
  assign func3       = r_instr[14:12];
  assign func7       = r_instr[30];
  assign fetch_count = r_fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign    = r_misalign;
`else
  assign misalign    = 1'b0;
`endif

endmodule
